// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM encoding and default geometry.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int unsigned APB_WIDTH_DEF   = 8;
  localparam int unsigned APB_TIMEOUT_DEF = 15;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts PREADY-low ACCESS cycles; expired asserts once the count reaches LIMIT.
module apb_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign expired = (cnt_q >= LIMIT_C);

  // Saturate at the limit so the count can never wrap while stalled
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: takes single local read/write commands and runs SETUP/ACCESS
// towards two slaves, with wait-state support and a stall timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned WIDTH   = APB_WIDTH_DEF,
  parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic             i_PCLK,
  input  logic             i_PRESETn,
  input  logic             i_transfer,
  input  logic             i_write,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_error,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_PSEL1,
  output logic             o_PSEL2,
  output logic             o_PENABLE,
  output logic             o_PWRITE,
  output logic [WIDTH-1:0] o_PADDR,
  output logic [WIDTH-1:0] o_PWDATA,
  input  logic [WIDTH-1:0] i_PRDATA1,
  input  logic [WIDTH-1:0] i_PRDATA2,
  input  logic             i_PREADY1,
  input  logic             i_PREADY2
);

  apb_state_e       state_q, state_d;
  logic             pwrite_q, pwrite_d;
  logic [WIDTH-1:0] paddr_q, paddr_d;
  logic [WIDTH-1:0] pwdata_q, pwdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             psel1_q, psel1_d;
  logic             psel2_q, psel2_d;
  logic             penable_q, penable_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             pready_sel;
  logic [WIDTH-1:0] prdata_sel;
  logic             accept;
  logic             expired;

  // Only the slave addressed by the latched MSB is listened to
  assign pready_sel = paddr_q[WIDTH-1] ? i_PREADY2 : i_PREADY1;
  assign prdata_sel = paddr_q[WIDTH-1] ? i_PRDATA2 : i_PRDATA1;

  assign o_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready_sel);
  assign accept  = i_transfer && o_ready;

  apb_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk     (i_PCLK),
    .rst_n   (i_PRESETn),
    .clear   (state_q != ACCESS),
    .en      ((state_q == ACCESS) && !pready_sel),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    error_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_transfer) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // Ready takes priority over an expiring wait count
        if (pready_sel) begin
          done_d = 1'b1;
          if (!pwrite_q) rdata_d = prdata_sel;
          state_d = i_transfer ? SETUP : IDLE;
        end else if (expired) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      pwrite_d = i_write;
      paddr_d  = i_addr;
      pwdata_d = i_wdata;
    end

    // Selects follow the next state and next address so they stay registered
    psel1_d   = (state_d != IDLE) && !paddr_d[WIDTH-1];
    psel2_d   = (state_d != IDLE) &&  paddr_d[WIDTH-1];
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      state_q   <= IDLE;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign o_PSEL1   = psel1_q;
  assign o_PSEL2   = psel2_q;
  assign o_PENABLE = penable_q;
  assign o_PWRITE  = pwrite_q;
  assign o_PADDR   = paddr_q;
  assign o_PWDATA  = pwdata_q;
  assign o_rdata   = rdata_q;
  assign o_done    = done_q;
  assign o_error   = error_q;

endmodule
